// File: rtl/instruction_fetch_unit.sv
// Fetch stage: owns the PC, issues word reads to instruction memory and presents
// one captured instruction at a time to the decoder under a valid/stall handshake.
module instruction_fetch_unit #(
  parameter int                    ADDR_WIDTH = 16,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
  input  logic                  clock,
  input  logic                  reset,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic                  mem_read,
  input  logic [15:0]           mem_rdata,
  input  logic                  mem_ready,
  input  logic                  stall,
  input  logic                  redirect,
  input  logic [ADDR_WIDTH-1:0] redirect_pc,
  input  logic                  halt,
  output logic [15:0]           instruction,
  output logic [ADDR_WIDTH-1:0] instr_pc,
  output logic                  instr_valid,
  output logic                  halted
);

  localparam logic [15:0] INSTR_RESET = 16'hFFFF;
  localparam logic [15:0] INSTR_NOP   = 16'hE000;

  typedef enum logic [2:0] {
    S_FETCH, S_WAIT, S_HOLD, S_FLUSH, S_HALTED
  } state_t;

  state_t                  state, state_nxt;
  logic [ADDR_WIDTH-1:0]   pc, pc_nxt;
  logic [ADDR_WIDTH-1:0]   ipc_nxt;
  logic [15:0]             instr_nxt;
  logic                    vld_nxt, halted_nxt, read_nxt;
  logic                    capture;

  // Gating with mem_read keeps a stray mem_ready in the idle FETCH cycle
  // right after reset from capturing garbage.
  assign capture = mem_read & mem_ready;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state       <= S_FETCH;
      pc          <= RESET_PC;
      mem_addr    <= RESET_PC;
      mem_read    <= 1'b0;
      instruction <= INSTR_RESET;
      instr_pc    <= '0;
      instr_valid <= 1'b0;
      halted      <= 1'b0;
    end else begin
      state       <= state_nxt;
      pc          <= pc_nxt;
      mem_addr    <= pc_nxt;
      mem_read    <= read_nxt;
      instruction <= instr_nxt;
      instr_pc    <= ipc_nxt;
      instr_valid <= vld_nxt;
      halted      <= halted_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    pc_nxt     = pc;
    ipc_nxt    = instr_pc;
    instr_nxt  = instruction;
    vld_nxt    = instr_valid;
    halted_nxt = halted;

    if (state == S_HALTED) begin
      // only reset leaves HALTED
    end else if (redirect) begin
      state_nxt = S_FLUSH;
      pc_nxt    = redirect_pc;
      vld_nxt   = 1'b0;
      instr_nxt = INSTR_NOP;
    end else if (halt) begin
      state_nxt  = S_HALTED;
      vld_nxt    = 1'b0;
      halted_nxt = 1'b1;
    end else begin
      case (state)
        S_FETCH, S_WAIT: begin
          if (capture) begin
            instr_nxt = mem_rdata;
            ipc_nxt   = pc;
            pc_nxt    = pc + 1'b1;
            vld_nxt   = 1'b1;
            state_nxt = S_HOLD;
          end else begin
            state_nxt = S_WAIT;
          end
        end
        S_HOLD: begin
          if (instr_valid && !stall) begin
            vld_nxt   = 1'b0;
            state_nxt = S_FETCH;
          end
        end
        S_FLUSH: state_nxt = S_FETCH;
        default: state_nxt = S_FETCH;
      endcase
    end

    // mem_read/mem_addr are registered, so they follow the state being entered
    read_nxt = (state_nxt == S_FETCH) || (state_nxt == S_WAIT);
  end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Bench for instruction_fetch_unit: table of fetches with wait/stall shaping,
// scoreboarded memory returns, redirect/halt/reset sequences and a PC-wrap instance.
module tb_instruction_fetch_unit;

  logic        clock = 1'b0;
  logic        reset;
  always #5 clock = ~clock;

  // main instance
  logic [15:0] mem_addr, redirect_pc, instr_pc, instruction, mem_rdata;
  logic        mem_read, mem_ready, stall, redirect, halt, instr_valid, halted;

  instruction_fetch_unit #(.ADDR_WIDTH(16), .RESET_PC(16'h0000)) dut (
    .clock(clock), .reset(reset),
    .mem_addr(mem_addr), .mem_read(mem_read), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .stall(stall), .redirect(redirect), .redirect_pc(redirect_pc), .halt(halt),
    .instruction(instruction), .instr_pc(instr_pc), .instr_valid(instr_valid), .halted(halted)
  );

  // wrap instance: 4-bit PC starting at 15, zero-wait memory
  logic [3:0]  w_addr, w_ipc;
  logic [15:0] w_rdata, w_instr;
  logic        w_read, w_valid, w_halted;
  logic        w_stall = 1'b0, w_redirect = 1'b0, w_halt = 1'b0;
  logic [3:0]  w_rpc = 4'd0;

  assign w_rdata = 16'h3000 + {12'h000, w_addr};

  instruction_fetch_unit #(.ADDR_WIDTH(4), .RESET_PC(4'd15)) dut_w (
    .clock(clock), .reset(reset),
    .mem_addr(w_addr), .mem_read(w_read), .mem_rdata(w_rdata), .mem_ready(w_read),
    .stall(w_stall), .redirect(w_redirect), .redirect_pc(w_rpc), .halt(w_halt),
    .instruction(w_instr), .instr_pc(w_ipc), .instr_valid(w_valid), .halted(w_halted)
  );

  // memory model: ready after wait_req cycles of a held request
  logic [15:0] mem [0:31];
  int          wait_req;
  int          cnt;

  assign mem_ready = mem_read && (cnt >= wait_req);
  assign mem_rdata = mem[mem_addr[4:0]];

  always @(posedge clock or posedge reset) begin
    if (reset)                    cnt <= 0;
    else if (!mem_read || mem_ready) cnt <= 0;
    else                          cnt <= cnt + 1;
  end

  // scoreboard: every accepted memory return must appear once at the decoder
  typedef struct { logic [15:0] instr; logic [15:0] pc; } exp_t;
  exp_t sb[$];

  always @(posedge clock) begin
    if (!reset && mem_read && mem_ready && !redirect && !halt && !halted)
      sb.push_back('{mem_rdata, mem_addr});
  end

  typedef struct { int wt; int st; logic [15:0] instr; logic [15:0] pc; } vec_t;
  vec_t vt [8];

  int n_chk = 0;
  int n_fail = 0;
  logic wrap_done = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic pop_chk(input string name);
    exp_t e;
    if (sb.size() == 0) begin
      chk({name, "_sb_empty"}, 32'(sb.size()), 32'd1);
    end else begin
      e = sb.pop_front();
      chk({name, "_sb_instr"}, 32'(instruction), 32'(e.instr));
      chk({name, "_sb_pc"}, 32'(instr_pc), 32'(e.pc));
    end
  endtask

  task automatic wait_valid(input string name, output int n);
    n = 0;
    while (!instr_valid && n < 50) begin
      step();
      n++;
    end
    chk({name, "_timeout"}, 32'(instr_valid), 32'd1);
  endtask

  // wrap checks run alongside the main sequence after the first reset release
  initial begin
    int n;
    @(negedge reset);
    #1;
    step();
    chk("wrap_first_req", 32'({w_read, w_addr}), 32'({1'b1, 4'd15}));
    n = 0;
    while (!w_valid && n < 20) begin step(); n++; end
    chk("wrap_valid0", 32'(w_valid), 32'd1);
    chk("wrap_ipc0", 32'(w_ipc), 32'd15);
    chk("wrap_instr0", 32'(w_instr), 32'h300F);
    step();
    n = 0;
    while (!w_valid && n < 20) begin step(); n++; end
    chk("wrap_valid1", 32'(w_valid), 32'd1);
    chk("wrap_ipc1", 32'(w_ipc), 32'd0);
    chk("wrap_instr1", 32'(w_instr), 32'h3000);
    wrap_done = 1'b1;
  end

  initial begin
    int n;
    bit ok;
    logic [15:0] held;

    for (int i = 0; i < 32; i++) mem[i] = 16'h1000 + 16'(i);
    mem[7] = 16'h2A07;
    vt[0] = '{0, 0, 16'h1001, 16'd1};
    vt[1] = '{0, 0, 16'h1002, 16'd2};
    vt[2] = '{0, 0, 16'h1003, 16'd3};
    vt[3] = '{0, 0, 16'h1004, 16'd4};
    vt[4] = '{3, 0, 16'h1005, 16'd5};
    vt[5] = '{0, 0, 16'h1006, 16'd6};
    vt[6] = '{0, 5, 16'h2A07, 16'd7};
    vt[7] = '{1, 0, 16'h1008, 16'd8};

    stall = 1'b0; redirect = 1'b0; halt = 1'b0; redirect_pc = 16'h0; wait_req = 0;
    reset = 1'b1;
    repeat (2) @(posedge clock);
    #2;
    chk("rst_instr", 32'(instruction), 32'hFFFF);
    chk("rst_ipc", 32'(instr_pc), 32'd0);
    chk("rst_valid", 32'(instr_valid), 32'd0);
    chk("rst_halted", 32'(halted), 32'd0);
    chk("rst_read", 32'(mem_read), 32'd0);
    chk("rst_addr", 32'(mem_addr), 32'd0);
    @(posedge clock);
    #1 reset = 1'b0;

    wait_valid("first", n);
    chk("first_latency", 32'(n), 32'd2);
    chk("first_instr", 32'(instruction), 32'h1000);
    chk("first_ipc", 32'(instr_pc), 32'd0);
    pop_chk("first");
    step();
    chk("first_valid_1cyc", 32'(instr_valid), 32'd0);

    foreach (vt[i]) begin
      wait_req = vt[i].wt;
      stall = (vt[i].st > 0);
      ok = 1'b1;
      n = 0;
      while (!instr_valid && n < 50) begin
        if (!(mem_read && mem_addr == vt[i].pc)) ok = 1'b0;
        step();
        n++;
      end
      chk($sformatf("v%0d_req_hold", i), 32'(ok), 32'd1);
      chk($sformatf("v%0d_latency", i), 32'(n), 32'(vt[i].wt + 1));
      chk($sformatf("v%0d_instr", i), 32'(instruction), 32'(vt[i].instr));
      chk($sformatf("v%0d_ipc", i), 32'(instr_pc), 32'(vt[i].pc));
      pop_chk($sformatf("v%0d", i));
      ok = 1'b1;
      held = instruction;
      repeat (vt[i].st) begin
        step();
        if (!(instr_valid && instruction == held && instr_pc == vt[i].pc && !mem_read)) ok = 1'b0;
      end
      chk($sformatf("v%0d_stall_stable", i), 32'(ok), 32'd1);
      stall = 1'b0;
      step();
      chk($sformatf("v%0d_consumed", i), 32'(instr_valid), 32'd0);
      chk($sformatf("v%0d_next_fetch", i), 32'({mem_read, mem_addr}), 32'({1'b1, 16'(vt[i].pc + 16'd1)}));
    end

    // redirect from FETCH, then again during WAIT with data arriving the same cycle
    wait_req = 2;
    redirect = 1'b1; redirect_pc = 16'h0004;
    step();
    redirect = 1'b0;
    chk("rd1_flush", 32'({mem_read, instr_valid}), 32'd0);
    chk("rd1_nop", 32'(instruction), 32'hE000);
    chk("rd1_ipc", 32'(instr_pc), 32'd8);
    step();
    chk("rd1_fetch", 32'({mem_read, mem_addr}), 32'({1'b1, 16'd4}));
    step();
    step();
    chk("rd2_wait_hold", 32'({mem_read, mem_addr}), 32'({1'b1, 16'd4}));
    redirect = 1'b1; redirect_pc = 16'h0009;
    step();
    redirect = 1'b0;
    chk("rd2_flush", 32'({mem_read, instr_valid}), 32'd0);
    chk("rd2_nop", 32'(instruction), 32'hE000);
    chk("rd2_ipc", 32'(instr_pc), 32'd8);
    chk("rd2_discard", 32'(sb.size()), 32'd0);
    wait_req = 0;
    step();
    chk("rd2_fetch", 32'({mem_read, mem_addr}), 32'({1'b1, 16'd9}));
    step();
    chk("rd2_valid", 32'(instr_valid), 32'd1);
    chk("rd2_instr", 32'(instruction), 32'h1009);
    pop_chk("rd2");

    // halt in HOLD, then nothing but reset wakes it
    halt = 1'b1;
    step();
    halt = 1'b0;
    chk("halt_flag", 32'(halted), 32'd1);
    chk("halt_idle0", 32'({mem_read, instr_valid}), 32'd0);
    chk("halt_instr", 32'(instruction), 32'h1009);
    ok = 1'b1;
    repeat (20) begin
      step();
      if (mem_read || !halted || instr_valid) ok = 1'b0;
    end
    chk("halt_20cyc", 32'(ok), 32'd1);
    redirect = 1'b1; redirect_pc = 16'h0003;
    step();
    redirect = 1'b0;
    step();
    chk("halt_ign_rd", 32'({halted, mem_read}), 32'({1'b1, 1'b0}));
    chk("halt_ign_instr", 32'(instruction), 32'h1009);

    #3 reset = 1'b1;
    #1;
    chk("arst_instr", 32'(instruction), 32'hFFFF);
    chk("arst_state", 32'({halted, mem_read, instr_valid}), 32'd0);
    chk("arst_addr", 32'(mem_addr), 32'd0);
    @(posedge clock);
    #1 reset = 1'b0;
    wait_valid("rerun", n);
    chk("rerun_instr", 32'(instruction), 32'h1000);
    chk("rerun_ipc", 32'(instr_pc), 32'd0);
    pop_chk("rerun");

    n = 0;
    while (!wrap_done && n < 100) begin step(); n++; end
    chk("wrap_done", 32'(wrap_done), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
